// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM encoding, access-size
// codes, the default start of I/O space and a size-to-byte-count helper.
package mem_ctrl_pkg;

  // Controller states: waiting, reading bytes, writing bytes, handshake
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  // Load/store access size encodings (3 is reserved and behaves as a word)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Addresses at or above this value are memory-mapped I/O
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Instruction fetches are always a full word
  localparam logic [2:0] FETCH_LEN = 3'd4;

  // Number of bytes moved for a given load/store size code
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      SZ_BYTE: len = 3'd1;
      SZ_HALF: len = 3'd2;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port controller shared by instruction fetch and load/store.
// One transaction at a time; multi-byte accesses are serialised one byte per
// cycle, little-endian. RAM read data arrives one cycle after its address.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        io_buffer_full,
  input  logic        _if_req,
  input  logic [31:0] _if_addr,
  output logic        _if_ready,
  output logic [31:0] _if_data,
  input  logic        _ls_req,
  input  logic        _ls_we,
  input  logic [31:0] _ls_addr,
  input  logic [1:0]  _ls_size,
  input  logic [31:0] _ls_wdata,
  output logic        _ls_ready,
  output logic [31:0] _ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  // Transaction state
  mem_state_t  state_reg;
  logic [2:0]  cnt_reg;       // RD: address-phase index; WR: byte on the bus
  logic [2:0]  len_reg;       // bytes in the current transaction
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        is_ls_reg;     // current transaction belongs to load/store
  logic        prio_ls_reg;   // 1: load/store wins the next tie
  logic        wr_en_reg;     // byte on the bus is to be written this cycle

  // Registered outputs
  logic [31:0] mem_a_reg;
  logic [7:0]  mem_dout_reg;
  logic        if_ready_reg;
  logic        ls_ready_reg;
  logic [31:0] if_data_reg;
  logic [31:0] ls_rdata_reg;

  // Shadow of the RAM read pipeline: which byte index mem_din carries now
  logic        din_vld_reg;
  logic [1:0]  din_idx_reg;
  logic [31:0] rbuf_reg;

  // Request arbitration: the requester not served last wins a tie
  logic        req_any;
  logic        grant_ls;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic        req_write;
  logic        first_io_hold;

  assign req_any       = _if_req | _ls_req;
  assign grant_ls      = _ls_req & (~_if_req | prio_ls_reg);
  assign req_addr      = grant_ls ? _ls_addr : _if_addr;
  assign req_len       = grant_ls ? size_to_len(_ls_size) : FETCH_LEN;
  assign req_write     = grant_ls & _ls_we;
  assign first_io_hold = (req_addr >= IO_BASE) & io_buffer_full;

  // Next byte of the running transaction (address wraps modulo 2^32)
  logic [2:0]  cnt_inc;
  logic [31:0] next_addr;
  logic [7:0]  next_wbyte;
  logic        next_io_hold;

  assign cnt_inc      = cnt_reg + 3'd1;
  assign next_addr    = addr_reg + {29'd0, cnt_inc};
  assign next_wbyte   = wdata_reg[{cnt_inc[1:0], 3'b000} +: 8];
  assign next_io_hold = (next_addr >= IO_BASE) & io_buffer_full;

  // Byte-lane assembly: drop the returning RAM byte into its lane, and
  // zero the lanes beyond the access length for the result
  logic [31:0] rbuf_next;
  logic [31:0] rdata_masked;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = gi;
      localparam logic [2:0] LANE_NUM = gi;
      assign rbuf_next[8*gi +: 8] = (din_vld_reg && (din_idx_reg == LANE_IDX))
                                    ? mem_din : rbuf_reg[8*gi +: 8];
      assign rdata_masked[8*gi +: 8] = (len_reg > LANE_NUM)
                                       ? rbuf_next[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Track the RAM's one-cycle read latency; this follows the RAM even during
  // a CPU stall so that a byte returned in a frozen cycle is not lost
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_vld_reg <= 1'b0;
      din_idx_reg <= 2'd0;
      rbuf_reg    <= 32'd0;
    end else begin
      din_vld_reg <= (state_reg == ST_RD) && (cnt_reg < len_reg);
      din_idx_reg <= cnt_reg[1:0];
      if (state_reg == ST_RD) begin
        rbuf_reg <= rbuf_next;
      end
    end
  end

  // Main controller FSM with registered RAM-side and CPU-side outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 3'd0;
      len_reg      <= 3'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      is_ls_reg    <= 1'b0;
      prio_ls_reg  <= 1'b0;
      wr_en_reg    <= 1'b0;
      mem_a_reg    <= 32'd0;
      mem_dout_reg <= 8'd0;
      if_ready_reg <= 1'b0;
      ls_ready_reg <= 1'b0;
      if_data_reg  <= 32'd0;
      ls_rdata_reg <= 32'd0;
    end else if (rdy_in) begin
      case (state_reg)
        ST_IDLE: begin
          if (!_clear && req_any) begin
            addr_reg    <= req_addr;
            len_reg     <= req_len;
            wdata_reg   <= _ls_wdata;
            is_ls_reg   <= grant_ls;
            prio_ls_reg <= ~grant_ls;
            cnt_reg     <= 3'd0;
            mem_a_reg   <= req_addr;
            if (req_write) begin
              state_reg    <= ST_WR;
              mem_dout_reg <= _ls_wdata[7:0];
              wr_en_reg    <= ~first_io_hold;
            end else begin
              state_reg <= ST_RD;
              wr_en_reg <= 1'b0;
            end
          end
        end

        ST_RD: begin
          if (_clear) begin
            // Speculative read is squashed: no handshake, outputs untouched
            state_reg <= ST_IDLE;
          end else if (cnt_reg == len_reg) begin
            state_reg <= ST_DONE;
            if (is_ls_reg) begin
              ls_rdata_reg <= rdata_masked;
              ls_ready_reg <= 1'b1;
            end else begin
              if_data_reg  <= rdata_masked;
              if_ready_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_inc;
            // After the last address, hold it while the final byte returns
            if (cnt_inc < len_reg) begin
              mem_a_reg <= next_addr;
            end
          end
        end

        ST_WR: begin
          // Stores are architecturally committed, so a flush does not stop them
          if (wr_en_reg) begin
            if (cnt_reg == len_reg - 3'd1) begin
              state_reg    <= ST_DONE;
              wr_en_reg    <= 1'b0;
              ls_ready_reg <= 1'b1;
            end else begin
              cnt_reg      <= cnt_inc;
              mem_a_reg    <= next_addr;
              mem_dout_reg <= next_wbyte;
              wr_en_reg    <= ~next_io_hold;
            end
          end else if (!io_buffer_full) begin
            // UART has room again: release the held byte
            wr_en_reg <= 1'b1;
          end
        end

        ST_DONE: begin
          state_reg    <= ST_IDLE;
          cnt_reg      <= 3'd0;
          if_ready_reg <= 1'b0;
          ls_ready_reg <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // A stalled CPU cycle must never write, even with a byte staged
  assign mem_wr    = wr_en_reg & rdy_in;
  assign mem_a     = mem_a_reg;
  assign mem_dout  = mem_dout_reg;
  assign _if_ready = if_ready_reg;
  assign _if_data  = if_data_reg;
  assign _ls_ready = ls_ready_reg;
  assign _ls_rdata = ls_rdata_reg;

endmodule
